y86_regfile_wb: RTL and testbench
=================================

Name: y86_regfile_wb

Overview:
Parametrised, clocked successor to the combinational write-back stage for the Y86-64 datapath. It derives write destinations (dstE/dstM) from icode/rA/rB/Cnd and commits valE/valM into an internal register file on the clock edge. It provides two combinational read ports with optional write-through bypass for decode, plus a flattened register dump, a retirement counter and a sticky error flag. It sits between memory stage and decode; it is the sole owner of architectural register state.

Parameters:
DW, 64, data word width in bits
NUM_REGS, 15, number of architectural registers (index 0..NUM_REGS-1); index 4'hF is RNONE
RSP_IDX, 4, stack pointer register index
RSP_RESET, 0, reset value of register RSP_IDX (all other registers reset to 0)
BYPASS, 1, 1 = read ports return the same-cycle write data on address match; 0 = read registered state only
CNT_W, 32, retirement counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
wb_valid  in  1  instruction in write-back this cycle; writes occur only when high
icode  in  4  instruction code
rA  in  4  register A field
rB  in  4  register B field
cnd  in  1  condition result from execute; gates cmovXX
valE  in  DW  ALU result
valM  in  DW  memory read data
srcA  in  4  read port A address
srcB  in  4  read port B address
rvalA  out  DW  read data A
rvalB  out  DW  read data B
reg_dump  out  NUM_REGS*DW  register i at bits [i*DW +: DW]
retire_cnt  out  CNT_W  count of committed wb_valid cycles
wr_err  out  1  sticky: a write targeted an index that is not RNONE and is >= NUM_REGS

Behaviour:
- Reset (rst_n=0 at posedge): all registers 0 except reg[RSP_IDX]=RSP_RESET; retire_cnt=0; wr_err=0. Reset overrides a concurrent wb_valid, and no write occurs that cycle.
- Destination decode (combinational):
  - 2 cmovXX: dstE=cnd?rB:F
  - 3 irmovq, 6 OPq: dstE=rB
  - 5 mrmovq: dstM=rA
  - 8 call, 9 ret, A pushq: dstE=RSP_IDX
  - B popq: dstE=RSP_IDX, dstM=rA
  - all others: dstE=dstM=F
- Commit: at posedge with wb_valid=1 and rst_n=1, reg[dstE]<=valE and reg[dstM]<=valM. Latency is 1 cycle: the value is visible in reg_dump the cycle after.
- Collision dstE==dstM (popq %rsp): valM wins, so reg[RSP_IDX]=valM.
- Writes to F are suppressed. Writes to an index >= NUM_REGS (and not F) are suppressed and set wr_err, which holds until reset.
- wb_valid=0: no state change, retire_cnt holds.
- retire_cnt increments by 1 per committed cycle and wraps modulo 2^CNT_W. It counts suppressed and cnd=0 instructions too.
- Reads: srcX==F or srcX>=NUM_REGS returns 0. With BYPASS=1, wb_valid=1 and srcX matching the active dstM or dstE, rvalX returns the incoming value, with M priority over E. With BYPASS=0, rvalX always returns registered state.
- reg_dump always reflects registered state and never shows bypassed values.

Decomposition:
- Package y86_pkg holds:
  - icode constants: I_HALT..I_POPQ (0..B)
  - RNONE=4'hF and RSP=4
  - a typedef for the 4-bit register index
- Sub-module y86_dst_decode: combinational mapping {icode,rA,rB,cnd} to {dstE,dstM}. It is reused later by the pipelined hazard unit.

Test Plan:
1. Reset with RSP_RESET=64'h100 -> reg_dump all 0 except reg4=0x100; retire_cnt=0; wr_err=0.
2. irmovq (icode 3), rB=2, valE=0x1234, wb_valid=1 -> next cycle reg2=0x1234, retire_cnt=1; same-cycle rvalA with srcA=2 is 0x1234 when BYPASS=1 and the old value (0) when BYPASS=0.
3. cmovXX rA=1, rB=3, valE=0x55: cnd=0 -> reg3 unchanged, retire_cnt still increments; cnd=1 -> reg3=0x55.
4. popq %rsp (icode B, rA=4), valE=0x108, valM=0xBEEF -> reg4=0xBEEF; popq rA=6 with the same values -> reg4=0x108, reg6=0xBEEF.
5. NUM_REGS=8, mrmovq rA=9, valM=0x7 -> no register changes, wr_err=1 and stays 1 until rst_n=0.
6. wb_valid=1 irmovq rB=5 with rst_n=0 in the same cycle -> reg5=0, retire_cnt=0. Drive retire_cnt to 2^CNT_W-1 (CNT_W=4, 15 commits) then one more commit -> retire_cnt=0.

Source files
------------

// File: rtl/y86_regfile_wb_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86-64 write-back / register-file slice:
//   - instruction code constants (I_HALT .. I_POPQ)
//   - register index type, RNONE and RSP indices
//   - destination pair struct produced by the destination decoder
//   - idx_valid(): true when an index names a real register of the file
// ---------------------------------------------------------------------------
package y86_pkg;

   typedef logic [3:0] reg_idx_t;

   localparam reg_idx_t RNONE = 4'hF;
   localparam reg_idx_t RSP   = 4'h4;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   typedef struct packed {
      reg_idx_t dst_e;
      reg_idx_t dst_m;
   } dst_pair_t;

   // An index is a real register when it is not RNONE and lies below the
   // configured register count (nregs is one bit wider so 16 fits).
   function automatic logic idx_valid(input reg_idx_t idx, input logic [4:0] nregs);
      logic ok;
      if (idx == RNONE) begin
         ok = 1'b0;
      end else begin
         ok = ({1'b0, idx} < nregs);
      end
      return ok;
   endfunction

endpackage

// File: rtl/y86_regfile_wb_if.sv
// ---------------------------------------------------------------------------
// y86_regfile_wb_if
// Write-back / decode-read bundle of the register file.
//   wb_valid, icode, rA, rB, cnd, valE, valM : write-back instruction
//   srcA, srcB                              : read addresses from decode
//   rvalA, rvalB                            : read data back to decode
// master = pipeline side (drives write-back and read addresses)
// slave  = register file
// ---------------------------------------------------------------------------
interface y86_regfile_wb_if #(
   parameter int DW = 64
) ();
   import y86_pkg::*;

   logic          wb_valid;
   logic [3:0]    icode;
   reg_idx_t      rA;
   reg_idx_t      rB;
   logic          cnd;
   logic [DW-1:0] valE;
   logic [DW-1:0] valM;
   reg_idx_t      srcA;
   reg_idx_t      srcB;
   logic [DW-1:0] rvalA;
   logic [DW-1:0] rvalB;

   modport master (
      output wb_valid, icode, rA, rB, cnd, valE, valM, srcA, srcB,
      input  rvalA, rvalB
   );

   modport slave (
      input  wb_valid, icode, rA, rB, cnd, valE, valM, srcA, srcB,
      output rvalA, rvalB
   );
endinterface

// File: rtl/y86_regfile_wb_dst_decode.sv
// ---------------------------------------------------------------------------
// y86_dst_decode
// Combinational destination decode for Y86-64 write-back.
//   icode, rA, rB, cnd : instruction fields and condition result
//   dstE, dstM         : register indices for valE / valM (RNONE = none)
// Also used by the hazard unit, so it has no state and no clock.
// ---------------------------------------------------------------------------
module y86_dst_decode
   import y86_pkg::*;
#(
   parameter reg_idx_t RSP_IDX = RSP
) (
   input  logic [3:0] icode,
   input  reg_idx_t   rA,
   input  reg_idx_t   rB,
   input  logic       cnd,
   output reg_idx_t   dstE,
   output reg_idx_t   dstM
);

   // Map the instruction code onto its E and M destinations.
   always_comb begin
      dstE = RNONE;
      dstM = RNONE;
      case (icode)
         I_CMOVXX: begin
            // A failed condition turns the move into a no-write.
            if (cnd) begin
               dstE = rB;
            end else begin
               dstE = RNONE;
            end
         end
         I_IRMOVQ, I_OPQ: begin
            dstE = rB;
         end
         I_MRMOVQ: begin
            dstM = rA;
         end
         I_CALL, I_RET, I_PUSHQ: begin
            dstE = RSP_IDX;
         end
         I_POPQ: begin
            dstE = RSP_IDX;
            dstM = rA;
         end
         default: begin
            dstE = RNONE;
            dstM = RNONE;
         end
      endcase
   end

endmodule

// File: rtl/y86_regfile_wb.sv
// ---------------------------------------------------------------------------
// y86_regfile_wb
// Clocked Y86-64 write-back stage and architectural register file.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   wb         : y86_regfile_wb_if.slave (write-back fields, read ports)
//   reg_dump   : register i at bits [i*DW +: DW], registered state only
//   retire_cnt : committed wb_valid cycles, wraps modulo 2^CNT_W
//   wr_err     : sticky flag for writes to a non-RNONE index >= NUM_REGS
// Writes commit on the clock edge; read ports are combinational and, when
// BYPASS is set, forward the write data of the instruction in write-back.
// ---------------------------------------------------------------------------
module y86_regfile_wb
   import y86_pkg::*;
#(
   parameter int            DW        = 64,
   parameter int            NUM_REGS  = 15,
   parameter int            RSP_IDX   = 4,
   parameter logic [DW-1:0] RSP_RESET = '0,
   parameter bit            BYPASS    = 1'b1,
   parameter int            CNT_W     = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   y86_regfile_wb_if.slave        wb,
   output logic [NUM_REGS*DW-1:0] reg_dump,
   output logic [CNT_W-1:0]       retire_cnt,
   output logic                   wr_err
);

   localparam logic [4:0] NREGS_L = 5'(NUM_REGS);

   reg_idx_t      dst_e_s;
   reg_idx_t      dst_m_s;
   logic          we_e_s;
   logic          we_m_s;
   logic          err_s;
   logic [DW-1:0] regs_r   [NUM_REGS];
   logic [DW-1:0] regs_nxt_s [NUM_REGS];
   logic [CNT_W-1:0] cnt_r;
   logic          wr_err_r;

   y86_dst_decode #(
      .RSP_IDX (4'(RSP_IDX))
   ) u_dst_decode (
      .icode (wb.icode),
      .rA    (wb.rA),
      .rB    (wb.rB),
      .cnd   (wb.cnd),
      .dstE  (dst_e_s),
      .dstM  (dst_m_s)
   );

   // Qualify each destination: real register -> write, else flag if not RNONE.
   always_comb begin
      we_e_s = 1'b0;
      we_m_s = 1'b0;
      err_s  = 1'b0;
      if (wb.wb_valid) begin
         we_e_s = idx_valid(dst_e_s, NREGS_L);
         we_m_s = idx_valid(dst_m_s, NREGS_L);
         err_s  = ((dst_e_s != RNONE) && !we_e_s) ||
                  ((dst_m_s != RNONE) && !we_m_s);
      end else begin
         we_e_s = 1'b0;
         we_m_s = 1'b0;
         err_s  = 1'b0;
      end
   end

   // Next register values; M is tested first so popq %rsp keeps valM.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (we_m_s && (dst_m_s == 4'(i))) begin
            regs_nxt_s[i] = wb.valM;
         end else if (we_e_s && (dst_e_s == 4'(i))) begin
            regs_nxt_s[i] = wb.valE;
         end else begin
            regs_nxt_s[i] = regs_r[i];
         end
      end
   end

   // Register file, retirement counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (i == RSP_IDX) begin
               regs_r[i] <= RSP_RESET;
            end else begin
               regs_r[i] <= '0;
            end
         end
         cnt_r    <= '0;
         wr_err_r <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= regs_nxt_s[i];
         end
         if (wb.wb_valid) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_r <= cnt_r;
         end
         if (err_s) begin
            wr_err_r <= 1'b1;
         end else begin
            wr_err_r <= wr_err_r;
         end
      end
   end

   // One read port: registered value, optionally overridden by the
   // in-flight write (M before E). RNONE / out-of-range reads give 0 because
   // no loop index matches and the write enables exclude those indices.
   function automatic logic [DW-1:0] read_port(input reg_idx_t src);
      logic [DW-1:0] rd;
      rd = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (src == 4'(i)) begin
            rd = regs_r[i];
         end else begin
            rd = rd;
         end
      end
      if (BYPASS) begin
         if (we_m_s && (src == dst_m_s)) begin
            rd = wb.valM;
         end else if (we_e_s && (src == dst_e_s)) begin
            rd = wb.valE;
         end else begin
            rd = rd;
         end
      end else begin
         rd = rd;
      end
      return rd;
   endfunction

   // Read port A.
   always_comb begin
      wb.rvalA = read_port(wb.srcA);
   end

   // Read port B.
   always_comb begin
      wb.rvalB = read_port(wb.srcB);
   end

   // Flatten registered state for observation.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_dump
      assign reg_dump[g*DW +: DW] = regs_r[g];
   end

   assign retire_cnt = cnt_r;
   assign wr_err     = wr_err_r;

endmodule

// File: tb/tb_y86_regfile_wb.sv
// ---------------------------------------------------------------------------
// tb_y86_regfile_wb
// Two register files driven with identical stimulus:
//   dut0: 15 registers, bypass on
//   dut1:  8 registers, bypass off
// Both use RSP_RESET = 0x100 and a 4-bit retirement counter.
// ---------------------------------------------------------------------------
module tb_y86_regfile_wb;

   localparam int DW   = 64;
   localparam int NR0  = 15;
   localparam int NR1  = 8;
   localparam int CW   = 4;
   localparam logic [63:0] RSPR = 64'h100;

   logic clk;
   logic rst_n;
   logic [NR0*DW-1:0] dump0;
   logic [NR1*DW-1:0] dump1;
   logic [CW-1:0]     cnt0, cnt1;
   logic              err0, err1;

   y86_regfile_wb_if #(.DW(DW)) if0 ();
   y86_regfile_wb_if #(.DW(DW)) if1 ();

   y86_regfile_wb #(
      .DW(DW), .NUM_REGS(NR0), .RSP_IDX(4), .RSP_RESET(RSPR),
      .BYPASS(1'b1), .CNT_W(CW)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .wb(if0),
      .reg_dump(dump0), .retire_cnt(cnt0), .wr_err(err0)
   );

   y86_regfile_wb #(
      .DW(DW), .NUM_REGS(NR1), .RSP_IDX(4), .RSP_RESET(RSPR),
      .BYPASS(1'b0), .CNT_W(CW)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .wb(if1),
      .reg_dump(dump1), .retire_cnt(cnt1), .wr_err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference state: architectural registers per DUT, counter, error flag.
   logic [63:0] mreg [2][16];
   int          mcnt [2];
   bit          merr [2];

   // Current stimulus, remembered for the model update at the clock edge.
   bit         c_r, c_v, c_c;
   logic [3:0] c_ic, c_ra, c_rb, c_sa, c_sb;
   logic [63:0] c_e, c_m;

   function automatic int nregs(input int k);
      return (k == 0) ? NR0 : NR1;
   endfunction

   function automatic bit byp(input int k);
      return (k == 0);
   endfunction

   // Destinations from the instruction table: {dstE, dstM}.
   function automatic logic [7:0] dests(input logic [3:0] ic, input logic [3:0] ra,
                                        input logic [3:0] rb, input bit c);
      logic [3:0] e, m;
      e = 4'hF; m = 4'hF;
      if (ic == 4'h2) e = c ? rb : 4'hF;
      else if (ic == 4'h3 || ic == 4'h6) e = rb;
      else if (ic == 4'h5) m = ra;
      else if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA) e = 4'h4;
      else if (ic == 4'hB) begin e = 4'h4; m = ra; end
      return {e, m};
   endfunction

   function automatic logic [63:0] model_read(input int k, input logic [3:0] s);
      logic [7:0] d;
      d = dests(c_ic, c_ra, c_rb, c_c);
      if (s == 4'hF || int'(s) >= nregs(k)) return 64'd0;
      if (byp(k) && c_v) begin
         if (s == d[3:0]) return c_m;
         if (s == d[7:4]) return c_e;
      end
      return mreg[k][s];
   endfunction

   task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply inputs to both DUTs and check the combinational read ports.
   task automatic drv(input bit r, input bit v, input logic [3:0] ic, input logic [3:0] ra,
                      input logic [3:0] rb, input bit c, input logic [63:0] e,
                      input logic [63:0] m, input logic [3:0] sa, input logic [3:0] sb);
      c_r = r; c_v = v; c_ic = ic; c_ra = ra; c_rb = rb; c_c = c;
      c_e = e; c_m = m; c_sa = sa; c_sb = sb;
      rst_n = r;
      if0.wb_valid = v; if0.icode = ic; if0.rA = ra; if0.rB = rb; if0.cnd = c;
      if0.valE = e; if0.valM = m; if0.srcA = sa; if0.srcB = sb;
      if1.wb_valid = v; if1.icode = ic; if1.rA = ra; if1.rB = rb; if1.cnd = c;
      if1.valE = e; if1.valM = m; if1.srcA = sa; if1.srcB = sb;
      #1;
      if (r) begin
         chk("rvalA0", 1024'(if0.rvalA), 1024'(model_read(0, sa)));
         chk("rvalB0", 1024'(if0.rvalB), 1024'(model_read(0, sb)));
         chk("rvalA1", 1024'(if1.rvalA), 1024'(model_read(1, sa)));
         chk("rvalB1", 1024'(if1.rvalB), 1024'(model_read(1, sb)));
      end
   endtask

   // Clock edge: advance the model, then compare registered state.
   task automatic tick();
      logic [7:0] d;
      logic [1023:0] exp;
      @(posedge clk);
      d = dests(c_ic, c_ra, c_rb, c_c);
      for (int k = 0; k < 2; k++) begin
         if (!c_r) begin
            for (int i = 0; i < 16; i++) mreg[k][i] = 64'd0;
            mreg[k][4] = RSPR;
            mcnt[k] = 0;
            merr[k] = 1'b0;
         end else if (c_v) begin
            mcnt[k] = (mcnt[k] + 1) % (1 << CW);
            if (d[7:4] != 4'hF) begin
               if (int'(d[7:4]) < nregs(k)) mreg[k][d[7:4]] = c_e;
               else merr[k] = 1'b1;
            end
            if (d[3:0] != 4'hF) begin
               if (int'(d[3:0]) < nregs(k)) mreg[k][d[3:0]] = c_m;
               else merr[k] = 1'b1;
            end
         end
      end
      #1;
      exp = '0;
      for (int i = 0; i < NR0; i++) exp[i*64 +: 64] = mreg[0][i];
      chk("dump0", 1024'(dump0), exp);
      exp = '0;
      for (int i = 0; i < NR1; i++) exp[i*64 +: 64] = mreg[1][i];
      chk("dump1", 1024'(dump1), exp);
      chk("cnt0", 1024'(cnt0), 1024'(mcnt[0]));
      chk("cnt1", 1024'(cnt1), 1024'(mcnt[1]));
      chk("err0", 1024'(err0), 1024'(merr[0]));
      chk("err1", 1024'(err1), 1024'(merr[1]));
      @(negedge clk);
   endtask

   initial begin
      // Reset with a concurrent irmovq to r5: no write, counter stays 0.
      drv(1'b0, 1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'h999, 64'h0, 4'h0, 4'h0);
      tick();
      chk("rst_reg4", 1024'(dump0[4*64 +: 64]), 1024'(64'h100));
      chk("rst_reg5", 1024'(dump0[5*64 +: 64]), 1024'(64'h0));
      chk("rst_cnt", 1024'(cnt0), 1024'(4'd0));
      chk("rst_err", 1024'(err1), 1024'(1'b0));

      // irmovq 0x1234 -> r2, same-cycle read of r2.
      drv(1'b1, 1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 4'h2, 4'h4);
      chk("byp_on", 1024'(if0.rvalA), 1024'(64'h1234));
      chk("byp_off", 1024'(if1.rvalA), 1024'(64'h0));
      tick();
      chk("irmov_reg2", 1024'(dump1[2*64 +: 64]), 1024'(64'h1234));
      chk("irmov_cnt", 1024'(cnt0), 1024'(4'd1));

      // cmovXX r1 -> r3, condition false then true.
      drv(1'b1, 1'b1, 4'h2, 4'h1, 4'h3, 1'b0, 64'h55, 64'h0, 4'h3, 4'h1);
      tick();
      chk("cmov0_reg3", 1024'(dump0[3*64 +: 64]), 1024'(64'h0));
      chk("cmov0_cnt", 1024'(cnt0), 1024'(4'd2));
      drv(1'b1, 1'b1, 4'h2, 4'h1, 4'h3, 1'b1, 64'h55, 64'h0, 4'h3, 4'h1);
      tick();
      chk("cmov1_reg3", 1024'(dump0[3*64 +: 64]), 1024'(64'h55));

      // popq %rsp: valM wins; popq %rsi: both land.
      drv(1'b1, 1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hBEEF, 4'h4, 4'h6);
      chk("pop_rsp_byp", 1024'(if0.rvalA), 1024'(64'hBEEF));
      tick();
      chk("pop_rsp_reg4", 1024'(dump0[4*64 +: 64]), 1024'(64'hBEEF));
      drv(1'b1, 1'b1, 4'hB, 4'h6, 4'hF, 1'b0, 64'h108, 64'hBEEF, 4'h4, 4'h6);
      tick();
      chk("pop_rsi_reg4", 1024'(dump1[4*64 +: 64]), 1024'(64'h108));
      chk("pop_rsi_reg6", 1024'(dump1[6*64 +: 64]), 1024'(64'hBEEF));

      // mrmovq into r9: out of range for the 8-register file.
      drv(1'b1, 1'b1, 4'h5, 4'h9, 4'hF, 1'b0, 64'h0, 64'h7, 4'h9, 4'hF);
      tick();
      chk("oor_err1", 1024'(err1), 1024'(1'b1));
      chk("oor_err0", 1024'(err0), 1024'(1'b0));
      chk("oor_reg9", 1024'(dump0[9*64 +: 64]), 1024'(64'h7));

      // Idle cycle: nothing moves, error sticks.
      drv(1'b1, 1'b0, 4'h3, 4'h0, 4'h1, 1'b1, 64'hDEAD, 64'hBEEF, 4'h1, 4'h9);
      tick();
      chk("idle_err1", 1024'(err1), 1024'(1'b1));
      chk("idle_reg1", 1024'(dump0[1*64 +: 64]), 1024'(64'h0));

      // Randomized traffic, occasional reset.
      for (int n = 0; n < 400; n++) begin
         drv(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, {$urandom, $urandom},
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         tick();
      end

      // Counter wrap after reset: 15 commits then one more.
      drv(1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 4'h0, 4'h0);
      tick();
      chk("wrap_err_clr", 1024'(err1), 1024'(1'b0));
      for (int n = 0; n < 15; n++) begin
         drv(1'b1, 1'b1, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 4'h4, 4'h0);
         tick();
      end
      chk("wrap_cnt15", 1024'(cnt0), 1024'(4'd15));
      drv(1'b1, 1'b1, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 4'h4, 4'h0);
      tick();
      chk("wrap_cnt0", 1024'(cnt1), 1024'(4'd0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
